// File: rtl/if_buf_pkg.sv
// Shared fetch-stage definitions: default widths, fetch FSM encoding and the bubble word.
package if_buf_pkg;

  localparam int unsigned IF_PC_W    = 6;
  localparam int unsigned IF_INSTR_W = 16;

  localparam logic [IF_INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HELD  = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_skid_reg.sv
// Pending-word holding register for a fetch that completes while decode is stalled.
module if_skid_reg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [PC_W-1:0]   pc1_i,
  output logic [DATA_W-1:0] data_o,
  output logic [PC_W-1:0]   pc1_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q;
  logic [PC_W-1:0]   pc1_q;
  logic              valid_q;

  // Clear wins over load so a redirect always empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      data_q  <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      pc1_q   <= pc1_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign pc1_o   = pc1_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_buf.sv
// Instruction-fetch stage: PC, fetch handshake FSM and the IF/ID output register.
module if_buf
  import if_buf_pkg::*;
#(
  parameter int unsigned PC_W     = IF_PC_W,
  parameter int unsigned INSTR_W  = IF_INSTR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_haz,
  input  logic               in_br_taken,
  input  logic [PC_W-1:0]    in_br_target,
  input  logic [INSTR_W-1:0] in_imem_rdata,
  input  logic               in_imem_ack,
  output logic               out_imem_req,
  output logic [PC_W-1:0]    out_imem_addr,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_adder1,
  output logic               out_valid
);

  if_state_e          state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    adder1_q, adder1_d;
  logic               valid_q, valid_d;
  logic               run_q;

  logic               skid_load, skid_clear, skid_valid;
  logic [INSTR_W-1:0] skid_data;
  logic [PC_W-1:0]    skid_pc1;
  logic [PC_W-1:0]    pc_plus1;

  assign pc_plus1 = pc_q + PC_W'(1);

  if_skid_reg #(
    .DATA_W (INSTR_W),
    .PC_W   (PC_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (in_imem_rdata),
    .pc1_i   (pc_plus1),
    .data_o  (skid_data),
    .pc1_o   (skid_pc1),
    .valid_o (skid_valid)
  );

  // Next-state and IF/ID register update; a redirect outranks stall and ack.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    adder1_d   = adder1_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (in_br_taken && (state_q != ST_IDLE)) begin
      pc_d       = in_br_target;
      instr_d    = INSTR_W'(NOP_INSTR);
      adder1_d   = '0;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      state_d    = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (run_q) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (in_imem_ack) begin
            pc_d = pc_plus1;
            if (in_haz) begin
              skid_load = 1'b1;
              state_d   = ST_HELD;
            end else begin
              instr_d  = in_imem_rdata;
              adder1_d = pc_plus1;
              valid_d  = 1'b1;
            end
          end else if (!in_haz) begin
            instr_d  = INSTR_W'(NOP_INSTR);
            adder1_d = '0;
            valid_d  = 1'b0;
          end
        end
        ST_HELD: begin
          if (!in_haz) begin
            instr_d    = skid_valid ? skid_data : INSTR_W'(NOP_INSTR);
            adder1_d   = skid_valid ? skid_pc1 : '0;
            valid_d    = skid_valid;
            skid_clear = 1'b1;
            state_d    = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // run_q delays leaving IDLE by one edge so reset release is seen synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= PC_W'(RESET_PC);
      instr_q  <= '0;
      adder1_q <= '0;
      valid_q  <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      adder1_q <= adder1_d;
      valid_q  <= valid_d;
      run_q    <= 1'b1;
    end
  end

  assign out_imem_req  = (state_q == ST_FETCH);
  assign out_imem_addr = pc_q;
  assign out_instr     = instr_q;
  assign out_adder1    = adder1_q;
  assign out_valid     = valid_q;

endmodule

// File: tb/tb_if_buf.sv
// Scoreboard bench for if_buf: fetched words queued on ack, compared when they reach decode.
module tb_if_buf;

  logic        clk;
  logic        rst_n;
  logic        haz;
  logic        br_taken;
  logic [5:0]  br_target;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [15:0] instr;
  logic [5:0]  adder1;
  logic        valid;

  typedef struct packed {
    logic [15:0] instr;
    logic [5:0]  a1;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  if_buf #(.PC_W(6), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_haz        (haz),
    .in_br_taken   (br_taken),
    .in_br_target  (br_target),
    .in_imem_rdata (imem_rdata),
    .in_imem_ack   (imem_ack),
    .out_imem_req  (imem_req),
    .out_imem_addr (imem_addr),
    .out_instr     (instr),
    .out_adder1    (adder1),
    .out_valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = 16'h1000 + 16'(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_addr(input logic [5:0] a);
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr == a) return;
      @(negedge clk);
    end
    chk("wait_addr_timeout", 32'd0, 32'd1);
  endtask

  logic        s_req, s_ack, s_haz, s_br;
  logic [5:0]  s_tgt, s_addr, s_nxt;
  logic [15:0] p_instr;
  logic [5:0]  p_a1;
  logic        p_valid;
  exp_t        e;

  // Monitor: pre-edge inputs decide what the post-edge outputs must be.
  always @(posedge clk) begin
    if (rst_n) begin
      s_req = imem_req;  s_ack = imem_ack;  s_haz = haz;  s_br = br_taken;
      s_tgt = br_target; s_addr = imem_addr; s_nxt = imem_addr + 6'd1;
      p_instr = instr;   p_a1 = adder1;      p_valid = valid;
      #1;
      if (rst_n) begin
        if (s_br) begin
          sb_q.delete();
          chk("br_valid", 32'(valid), 32'd0);
          chk("br_instr", 32'(instr), 32'd0);
          chk("br_a1", 32'(adder1), 32'd0);
          chk("br_addr", 32'(imem_addr), 32'(s_tgt));
          chk("br_req", 32'(imem_req), 32'd1);
        end else begin
          if (s_req && s_ack) begin
            e.instr = 16'h1000 + 16'(s_addr);
            e.a1    = s_nxt;
            sb_q.push_back(e);
            chk("addr_inc", 32'(imem_addr), 32'(s_nxt));
          end else if (s_req) begin
            chk("addr_stable", 32'(imem_addr), 32'(s_addr));
            chk("req_stable", 32'(imem_req), 32'd1);
          end
          if (s_haz) begin
            chk("hold_instr", 32'(instr), 32'(p_instr));
            chk("hold_a1", 32'(adder1), 32'(p_a1));
            chk("hold_valid", 32'(valid), 32'(p_valid));
          end else if (valid) begin
            if (sb_q.size() == 0) begin
              chk("sb_unexpected_word", 32'(instr), 32'hFFFF_FFFF);
            end else begin
              e = sb_q.pop_front();
              chk("sb_instr", 32'(instr), 32'(e.instr));
              chk("sb_a1", 32'(adder1), 32'(e.a1));
            end
          end else begin
            chk("bubble_instr", 32'(instr), 32'd0);
            chk("bubble_a1", 32'(adder1), 32'd0);
          end
        end
      end
    end
  end

  logic [15:0] hold_instr;
  logic [5:0]  hold_a1;

  initial begin
    rst_n = 1'b0; haz = 1'b0; br_taken = 1'b0; br_target = '0; imem_ack = 1'b0;
    #1;
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_a1", 32'(adder1), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    repeat (3) @(negedge clk);
    imem_ack = 1'b1;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_instr", 32'(instr), 32'h1000 + 32'(i));
      chk("b2b_a1", 32'(adder1), 32'(i + 1));
      chk("b2b_valid", 32'(valid), 32'd1);
    end

    // Stall with an ack at PC=5
    wait_addr(6'd5);
    hold_instr = instr;
    hold_a1    = adder1;
    chk("pre_hold_instr", 32'(hold_instr), 32'h1004);
    haz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_req", 32'(imem_req), 32'd0);
      chk("held_instr", 32'(instr), 32'h1004);
      chk("held_a1", 32'(adder1), 32'd5);
    end
    haz = 1'b0;
    @(negedge clk);
    chk("release_instr", 32'(instr), 32'h1005);
    chk("release_a1", 32'(adder1), 32'd6);
    chk("release_valid", 32'(valid), 32'd1);

    // Branch with a same-cycle ack
    br_taken = 1'b1; br_target = 6'h20;
    @(negedge clk);
    br_taken = 1'b0;
    chk("br36_valid", 32'(valid), 32'd0);
    chk("br36_addr", 32'(imem_addr), 32'h20);
    @(negedge clk);
    chk("br36_instr", 32'(instr), 32'h1020);
    chk("br36_a1", 32'(adder1), 32'h21);

    // Branch while held
    haz = 1'b1;
    @(negedge clk);
    chk("held37_req", 32'(imem_req), 32'd0);
    br_taken = 1'b1; br_target = 6'h10;
    @(negedge clk);
    br_taken = 1'b0; haz = 1'b0;
    chk("br37_valid", 32'(valid), 32'd0);
    chk("br37_addr", 32'(imem_addr), 32'h10);
    @(negedge clk);
    chk("br37_instr", 32'(instr), 32'h1010);
    chk("br37_a1", 32'(adder1), 32'h11);

    // PC wrap
    br_taken = 1'b1; br_target = 6'h3F;
    @(negedge clk);
    br_taken = 1'b0;
    chk("wrap_addr_pre", 32'(imem_addr), 32'h3F);
    @(negedge clk);
    chk("wrap_instr", 32'(instr), 32'h103F);
    chk("wrap_a1", 32'(adder1), 32'd0);
    chk("wrap_addr", 32'(imem_addr), 32'd0);

    // No ack -> bubbles, address stable
    imem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("noack_valid", 32'(valid), 32'd0);
      chk("noack_addr", 32'(imem_addr), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      imem_ack  = ($urandom_range(0, 3) != 0);
      haz       = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 15) == 0);
      br_target = 6'($urandom_range(0, 63));
    end
    @(negedge clk);
    br_taken = 1'b0; haz = 1'b0; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_req", 32'(imem_req), 32'd1);

    // Asynchronous reset mid-request
    imem_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("arst_instr", 32'(instr), 32'd0);
    chk("arst_a1", 32'(adder1), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_req", 32'(imem_req), 32'd0);
    chk("arst_idle_valid", 32'(valid), 32'd0);
    @(negedge clk);
    chk("arst_first_req", 32'(imem_req), 32'd1);
    chk("arst_first_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    chk("arst_first_instr", 32'(instr), 32'h1000);
    chk("arst_first_a1", 32'(adder1), 32'd1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_buf.md
IF_BUF -- requirements
Module: if_buf

Interface
REQ-001 SHALL have parameter PC_W, default 6, PC and PC+1 width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_haz  in  1  decode-stage stall; hold outputs and PC.
REQ-007 SHALL have port in_br_taken  in  1  redirect fetch and flush the IF/ID slot.
REQ-008 SHALL have port in_br_target  in  PC_W  redirect address.
REQ-009 SHALL have port in_imem_rdata  in  INSTR_W  instruction word, valid only with in_imem_ack.
REQ-010 SHALL have port in_imem_ack  in  1  memory completes current request this cycle.
REQ-011 SHALL have port out_imem_req  out  1  fetch request.
REQ-012 SHALL have port out_imem_addr  out  PC_W  fetch address (= PC).
REQ-013 SHALL have port out_instr  out  INSTR_W  instruction to decode stage.
REQ-014 SHALL have port out_adder1  out  PC_W  PC+1 of the instruction in out_instr.
REQ-015 SHALL have port out_valid  out  1  out_instr holds a real instruction; 0 = bubble.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, HELD.
REQ-017 IDLE SHALL last exactly one cycle after reset release, req=0, then go to FETCH.
REQ-018 FETCH SHALL drive out_imem_req=1 and out_imem_addr=PC; in_imem_ack is sampled only in FETCH.
REQ-019 FETCH, ack=1, in_haz=0, in_br_taken=0: out_instr<=rdata, out_adder1<=PC+1, out_valid<=1, PC<=PC+1; stay in FETCH (zero-bubble back-to-back fetch).
REQ-020 FETCH, ack=1, in_haz=1, in_br_taken=0: word stored in pending register with pending PC+1; PC<=PC+1; outputs held; go to HELD.
REQ-021 FETCH, ack=0: outputs hold unless REQ-023 applies; PC and address stay stable while req=1.
REQ-022 HELD SHALL drive req=0; when in_haz falls to 0, pending word and PC+1 move to out_instr/out_adder1 with out_valid<=1 on that edge, then go to FETCH.
REQ-023 in_haz=0 with no new word for decode (FETCH without ack) SHALL load a bubble: out_valid<=0, out_instr<=0, out_adder1<=0.
REQ-024 in_br_taken=1 SHALL take priority over in_haz and ack in any non-IDLE state: PC<=in_br_target, out_instr<=0, out_adder1<=0, out_valid<=0, pending register discarded, any same-cycle ack discarded, next state FETCH.
REQ-025 in_br_taken in IDLE SHALL be ignored.
REQ-026 PC+1 SHALL wrap modulo 2^PC_W (63 -> 0 at default width) with no flag.
REQ-027 in_haz=1 with no branch SHALL hold out_instr, out_adder1, out_valid unchanged in every state.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, PC=RESET_PC, out_instr=0, out_adder1=0, out_valid=0, pending register cleared, out_imem_req=0.
REQ-029 Reset asserted mid-request SHALL abandon the request; an ack arriving while in IDLE SHALL be ignored.
REQ-030 Reset release SHALL be synchronized to clk; first req SHALL assert on the second rising edge after release.

Structure
REQ-031 FSM state encoding, PC_W, INSTR_W and the zero NOP constant SHALL live in the shared processor package.
REQ-032 The pending (skid) register SHALL be a sub-module named if_skid_reg (data+PC+1+valid, load/clear).
REQ-033 out_imem_req and out_imem_addr SHALL be decoded from registered state/PC only (no combinational path from inputs).

Verification
REQ-034 Reset, ack tied 1, rdata = 0x1000+addr -> out_instr 0x1000,0x1001,0x1002 on consecutive cycles, out_adder1 1,2,3, out_valid=1.
REQ-035 Ack at PC=5 with in_haz=1 for 3 cycles -> req=0 during hold, outputs unchanged, word 0x1005 appears on the edge after in_haz falls, out_adder1=6.
REQ-036 in_br_taken=1, target 0x20, ack same cycle -> ack word dropped, out_valid=0 next cycle, next req addr=0x20.
REQ-037 Branch while HELD with in_haz=1 -> pending word discarded, bubble out, fetch resumes at target.
REQ-038 PC=63, ack=1 -> out_adder1=0, next addr=0.
REQ-039 rst_n asserted while req=1 and ack pending -> outputs zero immediately (no clk), req=0, first fetch after release at RESET_PC.
